// File: rtl/seg_scan_ctrl.sv
// Six-digit seven-segment scan controller: double-buffered frame, guard gap between digits.
// Optional blink feature enabled by defining SEG_SCAN_BLINK_EN.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 6,
    parameter int SEG_W        = 7,
    parameter int PRESCALE     = 1000,
    parameter int GUARD_CYC    = 2
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 32
`endif
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [NUM_DIGITS*SEG_W-1:0] frame_in,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [NUM_DIGITS-1:0]       blank_mask,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]       blink_mask,
`endif
    output logic [SEG_W-1:0]            seg_out,
    output logic [NUM_DIGITS-1:0]       dig_sel,
    output logic                        frame_done
);

    localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (PRESCALE > GUARD_CYC) ? PRESCALE : GUARD_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [DIG_W-1:0] DIGIT_LAST = DIG_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            w_cnt_next;
    logic [DIG_W-1:0]            r_digit;
    logic [DIG_W-1:0]            w_digit_next;
    logic                        w_frame_end;
    logic [NUM_DIGITS*SEG_W-1:0] r_shadow;
    logic [NUM_DIGITS*SEG_W-1:0] r_active;
    logic                        r_pending;
    logic [SEG_W-1:0]            r_seg_out;
    logic [SEG_W-1:0]            w_seg_next;
    logic [NUM_DIGITS-1:0]       r_dig_sel;
    logic [NUM_DIGITS-1:0]       w_dig_sel_next;
    logic                        r_frame_done;
    logic [NUM_DIGITS-1:0]       w_onehot;
    logic [SEG_W-1:0]            w_digits [NUM_DIGITS];
    logic                        w_lit;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_digits[gi] = r_active[gi*SEG_W +: SEG_W];
            assign w_onehot[gi] = (r_digit == DIG_W'(gi));
        end
    endgenerate

`ifdef SEG_SCAN_BLINK_EN
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;

    // Phase 1 means the blink-masked digits are dark for this frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_end) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_lit = !blank_mask[r_digit] && !(r_blink_phase && blink_mask[r_digit]);
`else
    assign w_lit = !blank_mask[r_digit];
`endif

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_digit_next   = r_digit;
        w_frame_end    = 1'b0;
        w_seg_next     = '0;
        w_dig_sel_next = '0;
        if (!enable) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
            w_digit_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_GUARD;
                    w_cnt_next   = '0;
                end
                ST_GUARD: begin
                    if (r_cnt == GUARD_LAST) begin
                        w_state_next = ST_SHOW;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        w_state_next = ST_GUARD;
                        w_cnt_next   = '0;
                        if (r_digit == DIGIT_LAST) begin
                            w_digit_next = '0;
                            w_frame_end  = 1'b1;
                        end else begin
                            w_digit_next = r_digit + 1'b1;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
        // SHOW is only entered or held without a digit change, so r_digit is the digit shown next.
        if (w_state_next == ST_SHOW) begin
            w_dig_sel_next = w_onehot;
            w_seg_next     = w_lit ? w_digits[r_digit] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_digit      <= '0;
            r_seg_out    <= '0;
            r_dig_sel    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_digit      <= w_digit_next;
            r_seg_out    <= w_seg_next;
            r_dig_sel    <= w_dig_sel_next;
            r_frame_done <= w_frame_end;
        end
    end

    // Swap needs pending set and load needs it clear, so the two never collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else if (w_frame_end && r_pending) begin
            r_active  <= r_shadow;
            r_pending <= 1'b0;
        end else if (load_valid && !r_pending) begin
            r_shadow  <= frame_in;
            r_pending <= 1'b1;
        end
    end

    assign load_ready = !r_pending;
    assign seg_out    = r_seg_out;
    assign dig_sel    = r_dig_sel;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with PRESCALE=4, GUARD_CYC=1 (30-cycle frame).
// Blink scenario runs only when SEG_SCAN_BLINK_EN is defined.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [41:0] frame_in = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [5:0]  blank_mask = '0;
`ifdef SEG_SCAN_BLINK_EN
    logic [5:0]  blink_mask = '0;
`endif
    logic [6:0]  seg_out;
    logic [5:0]  dig_sel;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    // Digit i of the pattern frame lights segment i only.
    logic [41:0] pat_frame;
    logic [6:0]  pat_seg [6];

    seg_scan_ctrl #(
        .NUM_DIGITS(6),
        .SEG_W(7),
        .PRESCALE(4),
        .GUARD_CYC(1)
`ifdef SEG_SCAN_BLINK_EN
        ,
        .BLINK_FRAMES(2)
`endif
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .frame_in(frame_in),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .blank_mask(blank_mask),
`ifdef SEG_SCAN_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg_out(seg_out),
        .dig_sel(dig_sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dig(input logic [5:0] want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (dig_sel === want) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset;
        #2;
        total++;
        if (dig_sel !== 6'b0 || seg_out !== 7'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: dig_sel=%b seg_out=%h frame_done=%b want 0", dig_sel, seg_out, frame_done);
        end
        total++;
        if (load_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_load_ready: got %b want 1", load_ready);
        end
        step();
        @(negedge clk);
        reset_n = 1'b1;
        step();
        total++;
        if (dig_sel !== 6'b0) begin
            bad++;
            $display("FAIL idle_dark: dig_sel=%b want 000000", dig_sel);
        end
        $display("reset: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_scan;
        logic [5:0] exp_sel;
        enable = 1'b1;
        for (int j = 0; j <= 30; j++) begin
            step();
            exp_sel = 6'b0;
            if (j < 30 && (j % 5) != 0) exp_sel = 6'b1 << (j / 5);
            total++;
            if (dig_sel !== exp_sel) begin
                bad++;
                $display("FAIL scan_dig_sel[%0d]: got %b want %b", j, dig_sel, exp_sel);
            end
            total++;
            if (frame_done !== (j == 30)) begin
                bad++;
                $display("FAIL scan_frame_done[%0d]: got %b want %b", j, frame_done, (j == 30));
            end
        end
        $display("scan: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_load;
        bit ok;
        repeat (7) step();
        load_valid = 1'b1;
        frame_in   = 42'h3FF_FFFF_FFFF;
        step();
        total++;
        if (load_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_ready_drop: got %b want 0", load_ready);
        end
        frame_in = 42'h155_5555_5555;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            total++;
            if (load_ready !== 1'b0 || seg_out !== 7'h00) begin
                bad++;
                $display("FAIL load_pending_hold: load_ready=%b seg_out=%h want 0/00", load_ready, seg_out);
            end
            step();
        end
        load_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL load_frame_done_timeout: got no pulse want pulse");
        end
        wait_dig(6'b000001, ok);
        total++;
        if (!ok || seg_out !== 7'h7F || load_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_swap: seg_out=%h load_ready=%b want 7f/1", seg_out, load_ready);
        end
        $display("load: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_back_to_back;
        bit ok;
        wait_dig(6'b100000, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL b2b_wait_digit5: dig_sel=%b want 100000", dig_sel);
        end
        repeat (3) step();
        load_valid = 1'b1;
        frame_in   = pat_frame;
        step();
        load_valid = 1'b0;
        total++;
        if (frame_done !== 1'b1 || load_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_edge_capture: frame_done=%b load_ready=%b want 1/0", frame_done, load_ready);
        end
        wait_dig(6'b000001, ok);
        total++;
        if (!ok || seg_out !== 7'h7F) begin
            bad++;
            $display("FAIL b2b_no_early_swap: seg_out=%h want 7f", seg_out);
        end
        wait_fd(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL b2b_frame_done_timeout: got no pulse want pulse");
        end
        for (int i = 0; i < 6; i++) begin
            wait_dig(6'b1 << i, ok);
            total++;
            if (!ok || seg_out !== pat_seg[i]) begin
                bad++;
                $display("FAIL b2b_digit%0d: dig_sel=%b seg_out=%h want %h", i, dig_sel, seg_out, pat_seg[i]);
            end
        end
        total++;
        if (load_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready_after_swap: got %b want 1", load_ready);
        end
        $display("back_to_back: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_blank;
        bit ok;
        wait_fd(ok);
        blank_mask = 6'b000100;
        for (int i = 0; i < 6; i++) begin
            wait_dig(6'b1 << i, ok);
            total++;
            if (!ok || seg_out !== ((i == 2) ? 7'h00 : pat_seg[i])) begin
                bad++;
                $display("FAIL blank_digit%0d: dig_sel=%b seg_out=%h want %h", i, dig_sel,
                         seg_out, (i == 2) ? 7'h00 : pat_seg[i]);
            end
            if (i == 2) begin
                blank_mask = 6'b0;
                step();
                total++;
                if (dig_sel !== 6'b000100 || seg_out !== 7'h04) begin
                    bad++;
                    $display("FAIL blank_release: dig_sel=%b seg_out=%h want 000100/04", dig_sel, seg_out);
                end
            end
        end
        $display("blank: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_enable_drop;
        bit ok;
        wait_dig(6'b001000, ok);
        enable = 1'b0;
        step();
        total++;
        if (!ok || dig_sel !== 6'b0 || seg_out !== 7'h00) begin
            bad++;
            $display("FAIL enable_drop_dark: dig_sel=%b seg_out=%h want 0", dig_sel, seg_out);
        end
        repeat (3) step();
        total++;
        if (dig_sel !== 6'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL enable_idle_hold: dig_sel=%b frame_done=%b want 0", dig_sel, frame_done);
        end
        enable = 1'b1;
        step();
        total++;
        if (dig_sel !== 6'b0) begin
            bad++;
            $display("FAIL reenable_guard: dig_sel=%b want 000000", dig_sel);
        end
        step();
        total++;
        if (dig_sel !== 6'b000001 || seg_out !== 7'h01) begin
            bad++;
            $display("FAIL reenable_digit0: dig_sel=%b seg_out=%h want 000001/01", dig_sel, seg_out);
        end
        $display("enable_drop: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_reset_mid;
        bit ok;
        load_valid = 1'b1;
        frame_in   = 42'h3FF_FFFF_FFFF;
        step();
        load_valid = 1'b0;
        total++;
        if (load_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_preload_pending: load_ready=%b want 0", load_ready);
        end
        wait_dig(6'b001000, ok);
        reset_n = 1'b0;
        #1;
        total++;
        if (!ok || dig_sel !== 6'b0 || seg_out !== 7'h00 || load_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_async: dig_sel=%b seg_out=%h load_ready=%b want 0/00/1", dig_sel, seg_out, load_ready);
        end
        step();
        @(negedge clk);
        reset_n = 1'b1;
        step();
        total++;
        if (dig_sel !== 6'b0) begin
            bad++;
            $display("FAIL rst_restart_guard: dig_sel=%b want 000000", dig_sel);
        end
        step();
        total++;
        if (dig_sel !== 6'b000001 || seg_out !== 7'h00) begin
            bad++;
            $display("FAIL rst_active_cleared: dig_sel=%b seg_out=%h want 000001/00", dig_sel, seg_out);
        end
        $display("reset_mid: total=%0d bad=%0d", total, bad);
    endtask

`ifdef SEG_SCAN_BLINK_EN
    task automatic test_blink;
        bit ok;
        logic [6:0] exp_d0 [5];
        exp_d0[0] = 7'h00;
        exp_d0[1] = 7'h01;
        exp_d0[2] = 7'h00;
        exp_d0[3] = 7'h00;
        exp_d0[4] = 7'h01;
        enable  = 1'b0;
        reset_n = 1'b0;
        step();
        @(negedge clk);
        reset_n    = 1'b1;
        blink_mask = 6'b000001;
        load_valid = 1'b1;
        frame_in   = pat_frame;
        step();
        load_valid = 1'b0;
        enable     = 1'b1;
        for (int f = 0; f < 5; f++) begin
            wait_dig(6'b000001, ok);
            total++;
            if (!ok || seg_out !== exp_d0[f]) begin
                bad++;
                $display("FAIL blink_frame%0d_digit0: dig_sel=%b seg_out=%h want %h", f, dig_sel, seg_out, exp_d0[f]);
            end
            wait_dig(6'b000010, ok);
            if (f > 0) begin
                total++;
                if (!ok || seg_out !== 7'h02) begin
                    bad++;
                    $display("FAIL blink_frame%0d_digit1: seg_out=%h want 02", f, seg_out);
                end
            end
            wait_fd(ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL blink_frame%0d_done_timeout: got no pulse want pulse", f);
            end
        end
        $display("blink: total=%0d bad=%0d", total, bad);
    endtask
`endif

    initial begin
        pat_seg[0] = 7'h01;
        pat_seg[1] = 7'h02;
        pat_seg[2] = 7'h04;
        pat_seg[3] = 7'h08;
        pat_seg[4] = 7'h10;
        pat_seg[5] = 7'h20;
        pat_frame  = {7'h20, 7'h10, 7'h08, 7'h04, 7'h02, 7'h01};
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_blank();
        test_enable_drop();
        test_reset_mid();
`ifdef SEG_SCAN_BLINK_EN
        test_blink();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
